// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D sampler slice.
// Holds the FSM state enum, result width and the SPI command word builder.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX1,
    GAP,
    TX2,
    CMPLT
  } a2d_state_t;

  localparam int A2D_RES_W  = 12;
  localparam int A2D_CHAN_W = 3;

  function automatic logic [15:0] a2d_cmd(
    input logic [A2D_CHAN_W-1:0] ch
  );
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_gap_timer.sv
// Loadable down-counter timing the idle gap between two SPI frames.
// Ports: clk, rst_n, load_i/load_val_i (preset), en_i (count), tc_o (last count).
module a2d_gap_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Loaded with the gap length, so a count of one marks the final gap cycle.
  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/a2d_sampler.sv
// Sequences the two SPI frames of one A2D conversion and returns the result.
// Ports: clk, rst_n, strt_cnv/chnnl in, busy/cnv_cmplt/res out, wrt/cmd/done/rd_data to SPI.
// Build option A2D_AVG4_EN: four conversion pairs per request, res = truncated mean.
import a2d_pkg::*;

module a2d_sampler #(
  parameter int GAP_CYCLES = 2,
  parameter int CHAN_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 strt_cnv,
  input  logic [CHAN_W-1:0]    chnnl,
  output logic                 busy,
  output logic                 cnv_cmplt,
  output logic [A2D_RES_W-1:0] res,
  output logic                 wrt,
  output logic [15:0]          cmd,
  input  logic                 done,
  input  logic [15:0]          rd_data
);

  a2d_state_t           state_q;
  logic [CHAN_W-1:0]    chnnl_q;
  logic                 busy_q;
  logic                 cmplt_q;
  logic                 wrt_q;
  logic [A2D_RES_W-1:0] res_q;
  logic                 gap_load;
  logic                 gap_tc;
  logic                 tx1_done;
  logic                 tx2_done;
  logic                 unused_hi;

  assign tx1_done  = (state_q == TX1) && done;
  assign tx2_done  = (state_q == TX2) && done;
  assign unused_hi = ^rd_data[15:12];

`ifdef A2D_AVG4_EN
  logic [1:0]  pair_q;
  logic [13:0] sum_q;
  logic        to_tx1_q;
  logic [13:0] sum_nxt;
  logic        last_pair;

  assign sum_nxt   = sum_q + 14'(rd_data[11:0]);
  assign last_pair = (pair_q == 2'd3);
  assign gap_load  = tx1_done || (tx2_done && !last_pair);
`else
  assign gap_load  = tx1_done;
`endif

  a2d_gap_timer #(
    .CNT_W (4)
  ) u_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (gap_load),
    .load_val_i (4'(GAP_CYCLES)),
    .en_i       (state_q == GAP),
    .tc_o       (gap_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chnnl_q  <= '0;
      busy_q   <= 1'b0;
      cmplt_q  <= 1'b0;
      wrt_q    <= 1'b0;
      res_q    <= '0;
`ifdef A2D_AVG4_EN
      pair_q   <= 2'd0;
      sum_q    <= '0;
      to_tx1_q <= 1'b0;
`endif
    end else begin
      wrt_q   <= 1'b0;
      cmplt_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (strt_cnv) begin
            chnnl_q <= chnnl;
            wrt_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= TX1;
          end
        end
        TX1: begin
          if (done) state_q <= GAP;
        end
        GAP: begin
          if (gap_tc) begin
            wrt_q    <= 1'b1;
`ifdef A2D_AVG4_EN
            to_tx1_q <= 1'b0;
            state_q  <= to_tx1_q ? TX1 : TX2;
`else
            state_q  <= TX2;
`endif
          end
        end
        TX2: begin
          if (done) begin
`ifdef A2D_AVG4_EN
            if (last_pair) begin
              res_q   <= sum_nxt[13:2];
              sum_q   <= '0;
              pair_q  <= 2'd0;
              cmplt_q <= 1'b1;
              state_q <= CMPLT;
            end else begin
              sum_q    <= sum_nxt;
              pair_q   <= pair_q + 2'd1;
              to_tx1_q <= 1'b1;
              state_q  <= GAP;
            end
`else
            res_q   <= rd_data[11:0];
            cmplt_q <= 1'b1;
            state_q <= CMPLT;
`endif
          end
        end
        CMPLT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign cnv_cmplt = cmplt_q;
  assign res       = res_q;
  assign wrt       = wrt_q;
  assign cmd       = a2d_cmd(chnnl_q);

endmodule

// File: tb/tb_a2d_sampler.sv
// Self-checking bench for a2d_sampler with a behavioural SPI responder.
// Expected results come from a per-request mean of programmed second-frame words.
module tb_a2d_sampler;

  localparam int GAP = 2;
`ifdef A2D_AVG4_EN
  localparam int NPAIR = 4;
`else
  localparam int NPAIR = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl = '0;
  logic        busy;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        spi_done = 1'b0;
  logic [15:0] spi_data = '0;
  logic        stray_done = 1'b0;
  logic [15:0] stray_data = '0;

  assign done    = spi_done | stray_done;
  assign rd_data = spi_done ? spi_data : stray_data;

  a2d_sampler #(
    .GAP_CYCLES (GAP),
    .CHAN_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .busy      (busy),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data)
  );

  always #10 clk = ~clk;

  int          cyc = 0;
  int          wrt_cnt = 0;
  int          cmplt_cnt = 0;
  logic [15:0] wcmd_q[$];
  int          wcyc_q[$];
  int          dcyc_q[$];
  logic [15:0] resp_q[$];
  logic [15:0] frm[8];
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wrt === 1'b1) begin
      wrt_cnt++;
      wcmd_q.push_back(cmd);
      wcyc_q.push_back(cyc);
    end
    if (cnv_cmplt === 1'b1) cmplt_cnt++;
    if (spi_done) dcyc_q.push_back(cyc);
  end

  // SPI master stand-in: answers each wrt after a random latency.
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        lat = int'($urandom_range(5, 2));
        repeat (lat) @(posedge clk);
        #1;
        spi_data = (resp_q.size() > 0) ? resp_q.pop_front() : 16'($urandom);
        spi_done = 1'b1;
        @(posedge clk);
        #1;
        spi_done = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  // Reference: truncated mean of the 12-bit second-frame words.
  function automatic logic [11:0] model_res();
    int sum = 0;
    for (int i = 0; i < NPAIR; i++) sum += int'(frm[2*i+1] & 16'h0FFF);
    return 12'(sum / NPAIR);
  endfunction

  task automatic rand_frm();
    for (int i = 0; i < 8; i++) frm[i] = 16'($urandom);
  endtask

  // mode 0 plain, 1 extra strt in TX1, 2 stray done in GAP,
  // 3 strt during the cnv_cmplt cycle; b2b starts in the current cycle.
  task automatic run_conv(input logic [2:0] ch, input int mode,
                          input bit b2b, input string tg);
    int w0, c0, d0, s, bad;
    bit ok, inj;
    logic [11:0] er;
    logic [15:0] ec;
    w0 = wrt_cnt;
    c0 = cmplt_cnt;
    d0 = dcyc_q.size();
    er = model_res();
    ec = 16'(ch) * 16'd2048;
    for (int i = 0; i < 2 * NPAIR; i++) resp_q.push_back(frm[i]);
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    chnnl = ch;
    strt_cnv = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    chnnl = 3'($urandom);
    ok = 1'b0;
    inj = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (cmplt_cnt > c0) begin
        ok = 1'b1;
        break;
      end
      if (mode == 1 && !inj && wrt_cnt > w0) begin
        inj = 1'b1;
        @(posedge clk);
        #1;
        chnnl = 3'd7;
        strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
      end
      if (mode == 2 && !inj && dcyc_q.size() > d0) begin
        inj = 1'b1;
        @(posedge clk);
        #1;
        stray_data = 16'($urandom);
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
      end
    end
    chk({tg, "_cmplt_seen"}, 32'(ok), 32'd1);
    chk({tg, "_busy_at_cmplt"}, 32'(busy), 32'd1);
    chk({tg, "_res"}, 32'(res), 32'(er));
    if (mode == 3) begin
      chnnl = ch;
      strt_cnv = 1'b1;
    end
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    @(negedge clk);
    #1;
    chk({tg, "_busy_after"}, 32'(busy), 32'd0);
    chk({tg, "_wrt_after"}, 32'(wrt), 32'd0);
    chk({tg, "_cmplt_cnt"}, 32'(cmplt_cnt - c0), 32'd1);
    chk({tg, "_wrt_cnt"}, 32'(wrt_cnt - w0), 32'(2 * NPAIR));
    chk({tg, "_cmd"}, 32'(wcmd_q[w0]), 32'(ec));
    bad = 0;
    for (int i = w0; i < wrt_cnt; i++) if (wcmd_q[i] !== ec) bad++;
    chk({tg, "_cmd_all"}, 32'(bad), 32'd0);
    chk({tg, "_wrt_lat"}, 32'(wcyc_q[w0] - s), 32'd1);
    chk({tg, "_gap"}, 32'(wcyc_q[w0+1] - dcyc_q[d0]), 32'(GAP + 1));
  endtask

  initial begin
    int w0, c0;
    logic [11:0] r0;
    bit ok;
    #3;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // stray done in IDLE
    w0 = wrt_cnt;
    stray_data = 16'h0FFF;
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("idle_done_wrt", 32'(wrt_cnt - w0), 32'd0);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_res", 32'(res), 32'd0);

    // basic conversion
    for (int i = 0; i < 8; i += 2) frm[i] = 16'hFFFF;
`ifdef A2D_AVG4_EN
    frm[1] = 16'h0100;
    frm[3] = 16'h0101;
    frm[5] = 16'h0102;
    frm[7] = 16'h0105;
`else
    frm[1] = 16'h0ABC;
`endif
    run_conv(3'd5, 0, 1'b0, "basic");

    rand_frm();
    run_conv(3'd1, 1, 1'b0, "ign_busy");

    rand_frm();
    run_conv(3'($urandom), 2, 1'b0, "stray_gap");

    // stray done in IDLE leaves res alone
    r0 = res;
    w0 = wrt_cnt;
    stray_data = ~{4'h0, r0};
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("idle_done2_res", 32'(res), 32'(r0));
    chk("idle_done2_wrt", 32'(wrt_cnt - w0), 32'd0);

    rand_frm();
    run_conv(3'd3, 3, 1'b0, "cmplt_ign");

    rand_frm();
    run_conv(3'd6, 0, 1'b0, "pre_b2b");
    rand_frm();
    run_conv(3'd0, 0, 1'b1, "b2b");

    // reset during TX2
    rand_frm();
    c0 = cmplt_cnt;
    w0 = wrt_cnt;
    for (int i = 0; i < 2 * NPAIR; i++) resp_q.push_back(frm[i]);
    @(posedge clk);
    #1;
    chnnl = 3'd6;
    strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (wrt_cnt >= w0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_tx2", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wrt", 32'(wrt), 32'd0);
    chk("abort_res", 32'(res), 32'd0);
    chk("abort_cmd", 32'(cmd), 32'd0);
    repeat (10) @(posedge clk);
    resp_q.delete();
    #1;
    rst_n = 1'b1;
    rand_frm();
    run_conv(3'd2, 0, 1'b0, "post_rst");
    chk("abort_no_cmplt", 32'(cmplt_cnt - c0), 32'd1);

    for (int k = 0; k < 5; k++) begin
      rand_frm();
      run_conv(3'($urandom), 0, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
